mips_instr_encoder: RTL and testbench

//  Inverse of the single-cycle control decoder. Accepts abstract instructions
//  (operation enum + register/immediate fields) over a valid/ready handshake,

---
 rtl/mips_pkg.sv | 37 +++
 rtl/mips_word_pack.sv | 35 +++
 rtl/mips_instr_encoder.sv | 109 ++++++++++
 tb/tb_mips_instr_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: abstract op codes, primary opcodes and
// R-type function codes, plus the program-loader state type.
package mips_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_ADDI = 4'd8,
    OP_J    = 4'd9
  } enc_op_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: abstract op plus fields -> 32-bit MIPS word.
// Op codes outside the enum flag illegal and produce a zero word.
module mips_word_pack
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Fields not used by the selected format are simply not placed in the word.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_ADD};
      OP_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_SUB};
      OP_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_AND};
      OP_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_OR};
      OP_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_SLT};
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
      OP_J:    word = {OPC_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts abstract instructions, encodes them and writes them
// sequentially into instruction memory, one word per accepted instruction.
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  illegal,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] CAP_CNT  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_CNT  = (ADDR_WIDTH+1)'(1);

  enc_state_t  state;
  enc_state_t  next_state;
  logic        accept;
  logic        write_ok;
  logic        we_q;
  logic [31:0] pack_word;
  logic        pack_illegal;

  mips_word_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // A simultaneous start reopens the program, so nothing is accepted that cycle.
  assign in_ready = (state == ST_LOAD) && !start;
  assign accept   = in_valid && in_ready;
  assign write_ok = accept && !pack_illegal;
  assign im_we    = we_q && !start;
  assign full     = (count == CAP_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The last legal write moves straight to FULL so the next word is never accepted.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (start)                              next_state = ST_LOAD;
        else if (stop)                          next_state = ST_IDLE;
        else if (write_ok && count == LAST_CNT) next_state = ST_FULL;
      end
      ST_FULL: begin
        if (start)     next_state = ST_LOAD;
        else if (stop) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      count    <= '0;
      illegal  <= 1'b0;
      done     <= 1'b0;
    end else begin
      we_q    <= write_ok;
      illegal <= accept && pack_illegal;
      done    <= stop && !start;
      if (start) begin
        count <= '0;
      end else if (write_ok) begin
        im_addr  <= count[ADDR_WIDTH-1:0];
        im_wdata <= pack_word;
        count    <= count + ONE_CNT;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench: a behavioural loader model checked every cycle, plus
// hand-computed literal words and boundary checks.
module tb_mips_instr_encoder;

  localparam int AW  = 5;
  localparam int CAP = 32;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_FULL = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          stop;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          illegal;
  logic          done;

  int total = 0;
  int bad   = 0;

  int          m_mode    = M_IDLE;
  int          m_count   = 0;
  bit          m_we      = 0;
  int          m_addr    = 0;
  logic [31:0] m_word    = '0;
  bit          m_illegal = 0;
  bit          m_done    = 0;
  bit          m_rdy;
  bit          m_acc;
  bit          m_legal;

  int funct_tab [0:4] = '{32, 34, 36, 37, 42};
  int opc_tab   [0:3] = '{35, 43, 4, 8};

  mips_instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_target (in_target),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .count     (count),
    .full      (full),
    .illegal   (illegal),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word value assembled from field positions with plain arithmetic.
  function automatic logic [31:0] model_word(int op, longint rs, longint rt, longint rd,
                                             longint imm, longint tgt);
    longint w;
    if (op < 5)
      w = rs * (2**21) + rt * (2**16) + rd * (2**11) + funct_tab[op];
    else if (op < 9)
      w = longint'(opc_tab[op-5]) * (2**26) + rs * (2**21) + rt * (2**16) + imm;
    else
      w = 2 * (2**26) + tgt;
    return w[31:0];
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Loader model: predicts the outputs seen during the cycle after each edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_count = 0; m_we = 0; m_addr = 0;
      m_word = '0; m_illegal = 0; m_done = 0;
    end else begin
      m_rdy     = (m_mode == M_LOAD) && !start;
      m_acc     = in_valid && m_rdy;
      m_legal   = (int'(in_op) <= 9);
      m_we      = m_acc && m_legal;
      m_illegal = m_acc && !m_legal;
      m_done    = stop && !start;
      if (m_we) begin
        m_addr = m_count;
        m_word = model_word(int'(in_op), longint'(in_rs), longint'(in_rt), longint'(in_rd),
                            longint'(in_imm), longint'(in_target));
        m_count++;
      end
      if (start)                                 begin m_count = 0; m_mode = M_LOAD; end
      else if (stop)                             m_mode = M_IDLE;
      else if (m_mode == M_LOAD && m_count == CAP) m_mode = M_FULL;
    end
  end

  always @(negedge clk) begin
    check_output("m_ready",   {31'b0, in_ready}, {31'b0, (m_mode == M_LOAD) && !start});
    check_output("m_im_we",   {31'b0, im_we},    {31'b0, m_we && !start});
    if (m_we && !start) begin
      check_output("m_im_addr",  {27'b0, im_addr}, 32'(m_addr));
      check_output("m_im_wdata", im_wdata,         m_word);
    end
    check_output("m_count",   {26'b0, count},    32'(m_count));
    check_output("m_full",    {31'b0, full},     {31'b0, m_count == CAP});
    check_output("m_illegal", {31'b0, illegal},  {31'b0, m_illegal});
    check_output("m_done",    {31'b0, done},     {31'b0, m_done});
  end

  // Drives one cycle of inputs and returns mid-cycle so outputs can be sampled.
  task automatic apply_stimulus(bit st, bit sp, bit v, logic [3:0] op, logic [4:0] rs,
                                logic [4:0] rt, logic [4:0] rd, logic [15:0] imm,
                                logic [25:0] tg);
    @(posedge clk);
    #1;
    start = st; stop = sp; in_valid = v; in_op = op; in_rs = rs; in_rt = rt;
    in_rd = rd; in_imm = imm; in_target = tg;
    @(negedge clk);
  endtask

  task automatic send(logic [3:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                      logic [15:0] imm, logic [25:0] tg);
    apply_stimulus(0, 0, 1, op, rs, rt, rd, imm, tg);
  endtask

  task automatic idle();
    apply_stimulus(0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
  endtask

  task automatic ctrl(bit st, bit sp);
    apply_stimulus(st, sp, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; in_valid = 0; in_op = '0; in_rs = '0;
    in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_ready", {31'b0, in_ready}, 32'd0);
    check_output("rst_count", {26'b0, count},    32'd0);
    check_output("rst_wdata", im_wdata,          32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD rs=1 rt=2 rd=3 lands at address 0 one cycle later
    ctrl(1, 0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    check_output("t1_ready", {31'b0, in_ready}, 32'd1);
    idle();
    check_output("t1_we",    {31'b0, im_we},   32'd1);
    check_output("t1_addr",  {27'b0, im_addr}, 32'd0);
    check_output("t1_wdata", im_wdata,         32'h0022_1820);
    check_output("t1_count", {26'b0, count},   32'd1);

    send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'd0);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0);
    check_output("t2_we1",  {31'b0, im_we},   32'd1);
    check_output("t2_addr1",{27'b0, im_addr}, 32'd1);
    check_output("t2_lw",   im_wdata,         32'h8C08_0004);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
    check_output("t2_we2",  {31'b0, im_we},   32'd1);
    check_output("t2_beq",  im_wdata,         32'h1022_FFFF);
    idle();
    check_output("t2_we3",  {31'b0, im_we},   32'd1);
    check_output("t2_addr3",{27'b0, im_addr}, 32'd3);
    check_output("t2_j",    im_wdata,         32'h0800_0010);
    check_output("t2_count",{26'b0, count},   32'd4);

    send(4'd12, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
    idle();
    check_output("t3_illegal", {31'b0, illegal},  32'd1);
    check_output("t3_we",      {31'b0, im_we},    32'd0);
    check_output("t3_count",   {26'b0, count},    32'd4);
    check_output("t3_ready",   {31'b0, in_ready}, 32'd1);
    idle();
    check_output("t3_pulse",   {31'b0, illegal},  32'd0);

    // Fill all 32 words, then hold a 33rd instruction that must never be written
    ctrl(1, 0);
    for (int i = 0; i < CAP; i++)
      send(4'd8, 5'(i), 5'd1, 5'd0, 16'(i * 3), 26'd0);
    send(4'd8, 5'd7, 5'd7, 5'd0, 16'hBEEF, 26'd0);
    check_output("t4_we",    {31'b0, im_we},    32'd1);
    check_output("t4_addr",  {27'b0, im_addr},  32'd31);
    check_output("t4_full",  {31'b0, full},     32'd1);
    check_output("t4_ready", {31'b0, in_ready}, 32'd0);
    send(4'd8, 5'd7, 5'd7, 5'd0, 16'hBEEF, 26'd0);
    check_output("t4_nowe",  {31'b0, im_we},    32'd0);
    check_output("t4_cnt32", {26'b0, count},    32'd32);
    ctrl(1, 0);
    idle();
    check_output("t4_clr",   {26'b0, count},    32'd0);
    check_output("t4_rdy1",  {31'b0, in_ready}, 32'd1);

    // Start during a pending write cancels it
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    ctrl(1, 0);
    check_output("t5_cancel", {31'b0, im_we},    32'd0);
    idle();
    check_output("t5_count",  {26'b0, count},    32'd0);
    ctrl(1, 1);
    idle();
    check_output("t5_nodone", {31'b0, done},     32'd0);
    check_output("t5_load",   {31'b0, in_ready}, 32'd1);
    ctrl(0, 1);
    idle();
    check_output("t5_done",   {31'b0, done},     32'd1);
    check_output("t5_idle",   {31'b0, in_ready}, 32'd0);
    ctrl(0, 1);
    idle();
    check_output("t5_done_idle", {31'b0, done},  32'd1);

    // Asynchronous reset in the middle of a stream
    ctrl(1, 0);
    send(4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
    send(4'd1, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_output("t6_we",    {31'b0, im_we},    32'd0);
    check_output("t6_count", {26'b0, count},    32'd0);
    check_output("t6_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    check_output("t6_idle",  {31'b0, in_ready}, 32'd0);

    // Remaining formats and a late illegal code, checked by the model
    ctrl(1, 0);
    send(4'd3, 5'd31, 5'd16, 5'd1, 16'd0, 26'd0);
    send(4'd4, 5'd2, 5'd3, 5'd31, 16'hAAAA, 26'h3FFFFFF);
    send(4'd2, 5'd9, 5'd10, 5'd11, 16'd0, 26'd0);
    send(4'd6, 5'd29, 5'd31, 5'd0, 16'h8000, 26'd0);
    send(4'd15, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
    send(4'd8, 5'd0, 5'd1, 5'd0, 16'h7FFF, 26'd0);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
